msg_sequencer: RTL and testbench
================================

Name: msg_sequencer

Overview:
- Upstream feeder for the 5-bit-code-to-7-segment decoder.
- Holds a short message of 5-bit symbol codes and steps through it, one symbol per TICK_DIV clocks.
- Presents each code, registered, on `codigo` to drive the decoder's 5-bit input.
- Supports load, start, pause, stop and looping playback.

Parameters:
- MSG_LEN, 8: number of message slots; power of 2, ≥2.
- AW, 3: address width; must equal log2(MSG_LEN).
- TICK_DIV, 4: clock cycles each symbol is held; ≥2.
- BLANK, 5'd31: code output when not playing; the decoder maps it to all segments off.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active low.
- load_en  in  1  write enable for message memory.
- load_addr  in  AW  write slot.
- load_code  in  5  code to write.
- start  in  1  begin playback; level, sampled in IDLE only.
- last_idx  in  AW  index of final symbol; sampled on start.
- loop  in  1  wrap to slot 0 after last symbol; sampled live.
- pause  in  1  level; freezes playback while high.
- stop  in  1  abort to IDLE; highest priority after reset.
- codigo  out  5  current symbol code, registered.
- valid  out  1  high while codigo holds a message symbol.
- busy  out  1  high in RUN or HOLD.
- done  out  1  one-cycle pulse when a non-looping message finishes.

Behaviour:
- Reset (rst_n=0 at edge):
  - state=IDLE; idx=0; div=0.
  - All MSG_LEN slots set to BLANK.
  - codigo=BLANK; valid=0; busy=0; done=0.
- Priority per edge: reset > stop > all else. stop in any non-IDLE state takes effect next edge:
  - state=IDLE; codigo=BLANK; valid=0; busy=0.
  - done is not pulsed.
- FSM states: IDLE, RUN, HOLD, DONE.
- IDLE:
  - load_en=1 writes mem[load_addr]=load_code; load_en is ignored in every other state.
  - start=1 (and stop=0) at the next edge:
    - go to RUN with idx=0, div=0, lastr=last_idx.
    - codigo=mem[0]; valid=1; busy=1.
  - Same-cycle load_en with load_addr=0 and start: codigo takes load_code (write-through bypass). The write is also committed.
- RUN:
  - Each edge with pause=0: if div<TICK_DIV-1 then div+=1, else div=0 and advance.
  - Advance with idx<lastr: idx+=1; codigo=mem[idx+1].
  - Advance with idx==lastr and loop=1: idx=0; codigo=mem[0]; no gap, valid stays 1.
  - Advance with idx==lastr and loop=0: go to DONE; codigo=BLANK; valid=0; busy=0; done=1.
  - pause=1 at an edge: go to HOLD; div, idx and codigo are unchanged.
- HOLD:
  - Outputs frozen; busy=1; valid=1.
  - pause=0 at an edge: return to RUN. The next div increment occurs on the following edge.
  - Total cycles a symbol is shown = TICK_DIV + paused cycles + 1 per pause entry.
- DONE:
  - Lasts exactly one cycle with done=1.
  - Next edge: IDLE with done=0.
  - start is not honoured in DONE, so back-to-back runs are separated by at least one IDLE cycle.
- Timing:
  - First symbol appears 1 cycle after start is sampled.
  - Every symbol is held exactly TICK_DIV cycles when there is no pause.
- Widths: idx and lastr are AW bits; div is wide enough for TICK_DIV-1.
- last_idx=0 plays a single symbol. Slot contents are passed through unchecked; codes 20..31 appear blank at the decoder.
- pause in IDLE or DONE has no effect; start held high in RUN is ignored.

Test Plan:
- Reset, then idle: codigo=31, valid=0, busy=0, done=0; all slots read back as 31 by playing with last_idx=7.
- Load slots 0..3 = 0,1,2,3; last_idx=3, loop=0; pulse start (TICK_DIV=4) -> codigo 0,1,2,3, each held 4 cycles. Then codigo=31, valid=0, done=1 for exactly 1 cycle; IDLE next cycle.
- Same load, loop=1 -> sequence 0,1,2,3,0,1 with no blank gap. Assert stop during symbol 1 -> next cycle codigo=31, busy=0, done never asserted.
- Pause during the 2nd cycle of symbol 2 for 5 cycles -> codigo=2 remains for 4+5+1=10 cycles total, then codigo=3.
- During RUN, load_en=1 with addr 0, code 15 -> mem unchanged. In IDLE, load addr 0 code 16 with start in the same cycle -> first codigo=16.
- rst_n=0 mid-RUN -> at that edge codigo=31, busy=0, and all slots cleared (a subsequent run outputs 31s).

Source files
------------

// File: rtl/msg_sequencer.sv
// Message sequencer: stores a short list of 5-bit symbol codes and plays them
// out on codigo, one symbol per TICK_DIV clocks, for the 7-segment decoder.
module msg_sequencer #(
    parameter int         MSG_LEN  = 8,
    parameter int         AW       = 3,
    parameter int         TICK_DIV = 4,
    parameter logic [4:0] BLANK    = 5'd31
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [4:0]    load_code,
    input  logic          start,
    input  logic [AW-1:0] last_idx,
    input  logic          loop,
    input  logic          pause,
    input  logic          stop,
    output logic [4:0]    codigo,
    output logic          valid,
    output logic          busy,
    output logic          done
);

    localparam int             DW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0]  DIV_MAX = DW'(TICK_DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [AW-1:0] idx;
    logic [AW-1:0] lastr;
    logic [DW-1:0] div;
    logic [4:0]    mem [MSG_LEN];

    // Single sequential process: reset clears the message store too, and stop
    // overrides every state except IDLE, where it only blocks a start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            idx    <= '0;
            lastr  <= '0;
            div    <= '0;
            codigo <= BLANK;
            valid  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            for (int i = 0; i < MSG_LEN; i++) begin
                mem[i] <= BLANK;
            end
        end else if (stop && (state != S_IDLE)) begin
            state  <= S_IDLE;
            idx    <= '0;
            div    <= '0;
            codigo <= BLANK;
            valid  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (load_en) begin
                        mem[load_addr] <= load_code;
                    end
                    if (start && !stop) begin
                        state <= S_RUN;
                        idx   <= '0;
                        div   <= '0;
                        lastr <= last_idx;
                        valid <= 1'b1;
                        busy  <= 1'b1;
                        // A same-cycle write to slot 0 must be visible immediately.
                        if (load_en && (load_addr == '0)) begin
                            codigo <= load_code;
                        end else begin
                            codigo <= mem[0];
                        end
                    end
                end

                S_RUN: begin
                    if (pause) begin
                        state <= S_HOLD;
                    end else if (div < DIV_MAX) begin
                        div <= div + DW'(1);
                    end else begin
                        div <= '0;
                        if (idx < lastr) begin
                            idx    <= idx + AW'(1);
                            codigo <= mem[idx + AW'(1)];
                        end else if (loop) begin
                            idx    <= '0;
                            codigo <= mem[0];
                        end else begin
                            state  <= S_DONE;
                            codigo <= BLANK;
                            valid  <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end
                    end
                end

                // Resuming costs one edge without a div step, so each pause
                // entry lengthens the symbol by one extra cycle.
                S_HOLD: begin
                    if (!pause) begin
                        state <= S_RUN;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state  <= S_IDLE;
                    codigo <= BLANK;
                    valid  <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_sequencer.sv
// Self-checking bench for msg_sequencer: expected output streams are built
// from a model of the message store and the per-symbol hold-time rule.
module tb_msg_sequencer;

    localparam int         MSG_LEN  = 8;
    localparam int         AW       = 3;
    localparam int         TICK_DIV = 4;
    localparam logic [4:0] BLANK    = 5'd31;

    logic          clk;
    logic          rst_n;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [4:0]    load_code;
    logic          start;
    logic [AW-1:0] last_idx;
    logic          loop;
    logic          pause;
    logic          stop;
    logic [4:0]    codigo;
    logic          valid;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    logic [4:0] model_mem [MSG_LEN];

    msg_sequencer #(
        .MSG_LEN (MSG_LEN),
        .AW      (AW),
        .TICK_DIV(TICK_DIV),
        .BLANK   (BLANK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_code(load_code),
        .start    (start),
        .last_idx (last_idx),
        .loop     (loop),
        .pause    (pause),
        .stop     (stop),
        .codigo   (codigo),
        .valid    (valid),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_slot(input int addr, input logic [4:0] code);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_code = code;
        cyc();
        load_en = 1'b0;
        model_mem[addr] = code;
    endtask

    // Plays a message and compares every cycle with a stream built from the
    // model: symbol s shows model_mem[s mod (last+1)] for TICK_DIV cycles,
    // plus pause_len+1 cycles when it is the paused symbol.
    task automatic run_check(input string name, input int last, input bit lp,
                             input int nsyms, input int stop_extra, input bit do_stop,
                             input int pause_sym, input int pause_off, input int pause_len,
                             input bit hold_start, input bit run_load,
                             input bit bypass, input logic [4:0] bypass_code);
        logic [4:0] exp_q[$];
        int pstart;
        int hold;
        exp_q.delete();
        pstart = -1;
        if (bypass) model_mem[0] = bypass_code;
        for (int s = 0; s < nsyms; s++) begin
            hold = TICK_DIV;
            if (s == pause_sym) begin
                hold   = TICK_DIV + pause_len + 1;
                pstart = exp_q.size() + pause_off;
            end
            for (int h = 0; h < hold; h++) exp_q.push_back(model_mem[s % (last + 1)]);
        end
        for (int j = 0; j < stop_extra; j++) exp_q.push_back(model_mem[nsyms % (last + 1)]);

        start    = 1'b1;
        last_idx = AW'(last);
        loop     = lp;
        if (bypass) begin
            load_en   = 1'b1;
            load_addr = '0;
            load_code = bypass_code;
        end
        cyc();
        if (!hold_start) start = 1'b0;
        load_en  = 1'b0;
        last_idx = AW'($urandom_range(0, MSG_LEN - 1));

        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (codigo !== exp_q[k]) begin
                errors++;
                $display("[TB] FAIL %s codigo cycle %0d: got %0d, expected %0d",
                         name, k, codigo, exp_q[k]);
            end
            checks++;
            if ({valid, busy, done} !== 3'b110) begin
                errors++;
                $display("[TB] FAIL %s flags cycle %0d: got v/b/d=%b, expected 110",
                         name, k, {valid, busy, done});
            end
            pause     = (pstart >= 0) && (k >= pstart) && (k < pstart + pause_len);
            load_en   = run_load && (k == 1);
            load_addr = '0;
            load_code = 5'd15;
            if (k == exp_q.size() - 1) begin
                start = 1'b0;
                stop  = do_stop;
            end
            cyc();
        end
        load_en = 1'b0;
        pause   = 1'b0;

        checks++;
        if (codigo !== BLANK) begin
            errors++;
            $display("[TB] FAIL %s end codigo: got %0d, expected %0d", name, codigo, BLANK);
        end
        checks++;
        if ({valid, busy, done} !== {2'b00, !do_stop}) begin
            errors++;
            $display("[TB] FAIL %s end flags: got v/b/d=%b, expected %b",
                     name, {valid, busy, done}, {2'b00, !do_stop});
        end
        stop = 1'b0;
        cyc();
        checks++;
        if ({codigo, valid, busy, done} !== {BLANK, 3'b000}) begin
            errors++;
            $display("[TB] FAIL %s idle after: got codigo=%0d v/b/d=%b, expected %0d 000",
                     name, codigo, {valid, busy, done}, BLANK);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({codigo, valid, busy, done} !== {BLANK, 3'b000}) begin
            errors++;
            $display("[TB] FAIL reset outputs: got codigo=%0d v/b/d=%b, expected %0d 000",
                     codigo, {valid, busy, done}, BLANK);
        end
        rst_n = 1'b1;
        pause = 1'b1;
        cyc();
        cyc();
        pause = 1'b0;
        checks++;
        if ({codigo, valid, busy, done} !== {BLANK, 3'b000}) begin
            errors++;
            $display("[TB] FAIL idle outputs: got codigo=%0d v/b/d=%b, expected %0d 000",
                     codigo, {valid, busy, done}, BLANK);
        end
        for (int i = 0; i < MSG_LEN; i++) model_mem[i] = BLANK;
        run_check("reset_blank", 7, 0, 8, 0, 0, -1, 0, 0, 0, 0, 0, 5'd0);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) load_slot(i, 5'(i));
        run_check("basic", 3, 0, 4, 0, 0, -1, 0, 0, 0, 0, 0, 5'd0);
        run_check("single", 0, 0, 1, 0, 0, -1, 0, 0, 0, 0, 0, 5'd0);
    endtask

    task automatic test_loop_stop();
        run_check("loop_stop", 3, 1, 5, 2, 1, -1, 0, 0, 0, 0, 0, 5'd0);
    endtask

    task automatic test_pause();
        run_check("pause", 3, 0, 4, 0, 0, 2, 1, 5, 0, 0, 0, 5'd0);
    endtask

    task automatic test_load_rules();
        run_check("run_load", 3, 0, 4, 0, 0, -1, 0, 0, 1, 1, 0, 5'd0);
        run_check("after_run_load", 3, 0, 4, 0, 0, -1, 0, 0, 0, 0, 0, 5'd0);
        run_check("bypass", 3, 0, 4, 0, 0, -1, 0, 0, 0, 0, 1, 5'd16);
        run_check("bypass_commit", 3, 0, 4, 0, 0, -1, 0, 0, 0, 0, 0, 5'd0);
    endtask

    task automatic test_reset_mid_run();
        start    = 1'b1;
        last_idx = 3'd3;
        loop     = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        checks++;
        if (codigo !== model_mem[0]) begin
            errors++;
            $display("[TB] FAIL midrun pre codigo: got %0d, expected %0d", codigo, model_mem[0]);
        end
        rst_n = 1'b0;
        cyc();
        checks++;
        if ({codigo, valid, busy, done} !== {BLANK, 3'b000}) begin
            errors++;
            $display("[TB] FAIL midrun reset: got codigo=%0d v/b/d=%b, expected %0d 000",
                     codigo, {valid, busy, done}, BLANK);
        end
        rst_n = 1'b1;
        loop  = 1'b0;
        for (int i = 0; i < MSG_LEN; i++) model_mem[i] = BLANK;
        cyc();
        run_check("midrun_cleared", 7, 0, 8, 0, 0, -1, 0, 0, 0, 0, 0, 5'd0);
    endtask

    task automatic test_random();
        int last;
        bit lp;
        int nsyms;
        int sx;
        int psym;
        for (int t = 0; t < 8; t++) begin
            for (int n = 0; n < 4; n++) begin
                load_slot($urandom_range(0, MSG_LEN - 1), 5'($urandom_range(0, 31)));
            end
            last = $urandom_range(0, MSG_LEN - 1);
            lp   = 1'($urandom_range(0, 1));
            if (lp) begin
                nsyms = last + 1 + $urandom_range(0, 3);
                sx    = $urandom_range(0, TICK_DIV - 1);
            end else begin
                nsyms = last + 1;
                sx    = 0;
            end
            psym = ($urandom_range(0, 1) == 1) ? $urandom_range(0, nsyms - 1) : -1;
            run_check($sformatf("random%0d", t), last, lp, nsyms, sx, lp, psym,
                      $urandom_range(0, TICK_DIV - 1), $urandom_range(1, 4),
                      1'($urandom_range(0, 1)), 0, 0, 5'd0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_code = '0;
        start     = 1'b0;
        last_idx  = '0;
        loop      = 1'b0;
        pause     = 1'b0;
        stop      = 1'b0;
        test_reset();
        test_basic();
        test_loop_stop();
        test_pause();
        test_load_rules();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
